// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, buffers returned words with their PCs in a small FIFO
// and hands the head to decode. A redirect flushes the buffer and marks any
// in-flight response to be discarded.
//
// state  | meaning
// -------+-------------------------------------------------------------
// REQ    | may issue a fetch for fetch_pc when the buffer has space
// WAIT   | one request outstanding, its response will be buffered
// DROP   | one request outstanding, its response is stale and discarded
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instrCode,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];

  logic        w_req_valid;
  logic        w_handshake;
  logic        w_rsp_done;
  logic        w_push;
  logic        w_pop;
  logic        w_outstanding_next;
  logic [31:0] w_redirect_pc;

  // Handshake, push/pop and outstanding-request decode; requests depend on
  // registered state only.
  always_comb begin
    w_req_valid        = (r_state == ST_REQ) && (r_count < DEPTH_C);
    w_handshake        = w_req_valid && imem_req_ready;
    w_rsp_done         = (r_state != ST_REQ) && imem_rsp_valid;
    w_push             = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    w_pop              = (r_count != '0) && instr_ready;
    w_outstanding_next = w_handshake || ((r_state != ST_REQ) && !imem_rsp_valid);
    w_redirect_pc      = redirect_pc & 32'hFFFF_FFFC;
  end

  // Fetch FSM and PC tracking; redirect overrides normal sequencing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
    end else if (redirect_valid) begin
      r_fetch_pc <= w_redirect_pc;
      r_state    <= w_outstanding_next ? ST_DROP : ST_REQ;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_handshake) begin
            r_state    <= ST_WAIT;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        ST_WAIT, ST_DROP: begin
          if (w_rsp_done) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

  // Instruction buffer: circular FIFO of {pc, word}, flushed on redirect.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= 32'h0;
        r_fifo_pc[i]   <= 32'h0;
      end
    end else if (redirect_valid) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= imem_rsp_data;
        r_fifo_pc[r_wr_ptr]   <= r_req_pc;
        r_wr_ptr              <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign instr_valid    = (r_count != '0);
  assign instrCode      = r_fifo_data[r_rd_ptr];
  assign instr_pc       = r_fifo_pc[r_rd_ptr];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instrCode;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instrCode      (instrCode),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: next fetch address, whether a request is in flight, whether its
  // data will be kept, and the buffered {pc, word} entries.
  logic [31:0] m_fetch;
  bit          m_out;
  bit          m_keep;
  logic [31:0] m_out_pc;
  logic [63:0] m_q[$];
  bit          m_en = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_req_valid();
    return !m_out && (m_q.size() < DEPTH);
  endfunction

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_step();
    bit hs, pop;
    if (!reset_n) begin
      m_fetch = RPC;
      m_out   = 1'b0;
      m_keep  = 1'b0;
      m_q.delete();
      return;
    end
    hs  = m_req_valid() && imem_req_ready;
    pop = (m_q.size() != 0) && instr_ready;
    if (redirect_valid) begin
      m_q.delete();
      m_fetch = {redirect_pc[31:2], 2'b00};
      m_out   = hs || (m_out && !imem_rsp_valid);
      m_keep  = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_out && imem_rsp_valid) begin
        if (m_keep) m_q.push_back({m_out_pc, imem_rsp_data});
        m_out = 1'b0;
      end
      if (hs) begin
        m_out    = 1'b1;
        m_keep   = 1'b1;
        m_out_pc = m_fetch;
        m_fetch  = m_fetch + 32'd4;
      end
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_en) begin
      chk("req_valid", 32'(imem_req_valid), 32'(m_req_valid()));
      chk("req_addr", imem_req_addr, m_fetch);
      chk("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        chk("instrCode", instrCode, m_q[0][31:0]);
        chk("instr_pc", instr_pc, m_q[0][63:32]);
      end
    end
  end

  task automatic drive(bit rn, bit rdy, bit rv, logic [31:0] rd,
                       bit rdir, logic [31:0] rpc, bit irdy);
    @(negedge clk);
    #1;
    reset_n        = rn;
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    redirect_valid = rdir;
    redirect_pc    = rpc;
    instr_ready    = irdy;
    model_step();
  endtask

  bit          env_pend;
  int          env_wait;

  initial begin
    reset_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b0;
    m_fetch = RPC; m_out = 1'b0; m_keep = 1'b0; m_out_pc = 32'h0;

    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    m_en = 1'b1;

    // Reset state, then two fetches with single-cycle memory.
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instrCode", instrCode, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    drive(1, 1, 1, 32'h0050_0093, 0, 0, 0);
    chk("wait_no_req", 32'(imem_req_valid), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("i0_code", instrCode, 32'h0050_0093);
    chk("i0_pc", instr_pc, 32'h0);
    chk("second_req_addr", imem_req_addr, 32'h4);
    drive(1, 1, 1, 32'h00A0_0113, 0, 0, 0);

    // Buffer full: no request until decode consumes.
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_req_addr", imem_req_addr, 32'h8);
    drive(1, 1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("i1_code", instrCode, 32'h00A0_0113);
    chk("i1_pc", instr_pc, 32'h4);
    chk("reissue_valid", 32'(imem_req_valid), 32'd1);
    chk("reissue_addr", imem_req_addr, 32'h8);

    // Redirect while waiting for 0x8: stale data must be discarded.
    drive(1, 1, 0, 0, 1, 32'h100, 0);
    drive(1, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("redir_flush", 32'(instr_valid), 32'd0);
    chk("drop_no_req", 32'(imem_req_valid), 32'd0);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("redir_addr", imem_req_addr, 32'h100);
    chk("after_drop_empty", 32'(instr_valid), 32'd0);

    // Redirect coinciding with a response.
    drive(1, 1, 1, 32'h1111_1111, 1, 32'h203, 0);
    drive(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    chk("redir_rsp_addr", imem_req_addr, 32'h200);
    chk("redir_rsp_empty", 32'(instr_valid), 32'd0);

    // Address wrap.
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    drive(1, 1, 1, 32'h2222_2222, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1);
    chk("wrap_code", instrCode, 32'h2222_2222);
    chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr1", imem_req_addr, 32'h0);
    drive(1, 1, 1, 32'h3333_3333, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 1);
    chk("wrap_pc1", instr_pc, 32'h0);

    // Reset while waiting, then a stale response.
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 32'h4444_4444, 0, 0, 0);
    chk("rst2_valid", 32'(instr_valid), 32'd0);
    chk("rst2_addr", imem_req_addr, RPC);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk("stale_ignored", 32'(instr_valid), 32'd0);
    drive(1, 0, 1, 32'h5555_5555, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("post_rst_code", instrCode, 32'h5555_5555);
    chk("post_rst_pc", instr_pc, RPC);

    // Randomized traffic with a variable-latency memory.
    env_pend = 1'b0;
    env_wait = 0;
    for (int i = 0; i < 4000; i++) begin
      bit rn, rdy, rv, rdir, irdy;
      logic [31:0] rd, rpc;
      rn   = ($urandom_range(0, 249) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      irdy = ($urandom_range(0, 2) != 0);
      rdir = ($urandom_range(0, 19) == 0);
      rd   = $urandom;
      rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : 32'($urandom);
      rv   = 1'b0;
      if (env_pend) begin
        if (env_wait == 0) begin
          rv       = 1'b1;
          env_pend = 1'b0;
        end else begin
          env_wait--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        rv = 1'b1;
      end
      drive(rn, rdy, rv, rd, rdir, rpc, irdy);
      if (!rn) env_pend = 1'b0;
      else if (imem_req_valid && imem_req_ready) begin
        env_pend = 1'b1;
        env_wait = $urandom_range(0, 3);
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
